// File: rtl/hls_ctrl_sequencer_if.sv
// AXI-Lite master bundle between the sequencer and an HLS accelerator's
// s_axi_control port (6-bit register space, 32-bit data).
interface hls_ctrl_sequencer_if;
  logic        m_awvalid;
  logic        m_awready;
  logic [5:0]  m_awaddr;
  logic        m_wvalid;
  logic        m_wready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_bvalid;
  logic        m_bready;
  logic [1:0]  m_bresp;
  logic        m_arvalid;
  logic        m_arready;
  logic [5:0]  m_araddr;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;

  modport master (
    output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
           m_arvalid, m_araddr, m_rready,
    input  m_awready, m_wready, m_bvalid, m_bresp,
           m_arready, m_rvalid, m_rdata, m_rresp
  );

  modport slave (
    input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
           m_arvalid, m_araddr, m_rready,
    output m_awready, m_wready, m_bvalid, m_bresp,
           m_arready, m_rvalid, m_rdata, m_rresp
  );
endinterface

// File: rtl/hls_ctrl_sequencer.sv
// Runs one HLS accelerator job over AXI-Lite: program args, enable and start,
// wait for interrupt (with timeout), acknowledge ISR, read CTRL, report status.
module hls_ctrl_sequencer #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
  parameter logic [5:0]  ARG0_OFFSET    = 6'h10,
  parameter logic [5:0]  ARG1_OFFSET    = 6'h18
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_arg0,
  input  logic [31:0] cmd_arg1,
  output logic        done_valid,
  output logic [1:0]  done_err,
  output logic        busy,
  input  logic        interrupt,
  hls_ctrl_sequencer_if.master m,
  output logic [2:0]  state_dbg
);

  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid && ready; valids come from flops only and are held until that edge.
  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WAIT_B, S_WAIT_IRQ, S_CLR_ISR, S_READ_CTRL, S_WAIT_R, S_DONE
  } state_t;

  localparam logic [2:0] IDX_CTRL = 3'd4;
  localparam logic [2:0] IDX_ISR  = 3'd5;
  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_AXI  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] arg0_q, arg0_d;
  logic [31:0] arg1_q, arg1_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic [1:0]  err_q, err_d;
  logic        aw_pend_q, aw_pend_d;
  logic        w_pend_q, w_pend_d;
  logic        ar_pend_q, ar_pend_d;

  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        aw_done, w_done;
  logic        unused_rdata;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      arg0_q    <= '0;
      arg1_q    <= '0;
      tcnt_q    <= '0;
      err_q     <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      ar_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      arg0_q    <= arg0_d;
      arg1_q    <= arg1_d;
      tcnt_q    <= tcnt_d;
      err_q     <= err_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      ar_pend_q <= ar_pend_d;
    end
  end

  // Register list; index 5 is the ISR acknowledge issued from CLR_ISR.
  always_comb begin
    wr_addr = 6'h0C;
    wr_data = 32'd1;
    case (idx_q)
      3'd0:    begin wr_addr = ARG0_OFFSET; wr_data = arg0_q; end
      3'd1:    begin wr_addr = ARG1_OFFSET; wr_data = arg1_q; end
      3'd2:    wr_addr = 6'h04;
      3'd3:    wr_addr = 6'h08;
      3'd4:    wr_addr = 6'h00;
      default: wr_addr = 6'h0C;
    endcase
  end

  assign aw_done = !aw_pend_q || m.m_awready;
  assign w_done  = !w_pend_q  || m.m_wready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    arg0_d    = arg0_q;
    arg1_d    = arg1_q;
    tcnt_d    = tcnt_q;
    err_d     = err_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    ar_pend_d = ar_pend_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          arg0_d    = cmd_arg0;
          arg1_d    = cmd_arg1;
          idx_d     = 3'd0;
          err_d     = ERR_OK;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          state_d   = S_WRITE;
        end
      end
      S_WRITE, S_CLR_ISR: begin
        if (aw_pend_q && m.m_awready) aw_pend_d = 1'b0;
        if (w_pend_q && m.m_wready)   w_pend_d  = 1'b0;
        if (aw_done && w_done)        state_d   = S_WAIT_B;
      end
      S_WAIT_B: begin
        if (m.m_bvalid) begin
          if (m.m_bresp != 2'b00) begin
            err_d   = ERR_AXI;
            state_d = S_DONE;
          end else if (idx_q == IDX_CTRL) begin
            tcnt_d  = '0;
            state_d = S_WAIT_IRQ;
          end else if (idx_q == IDX_ISR) begin
            ar_pend_d = 1'b1;
            state_d   = S_READ_CTRL;
          end else begin
            idx_d     = idx_q + 3'd1;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = S_WRITE;
          end
        end
      end
      S_WAIT_IRQ: begin
        // Interrupt beats a timeout that lands in the same cycle.
        if (interrupt) begin
          idx_d     = IDX_ISR;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          state_d   = S_CLR_ISR;
        end else if (tcnt_q == TIMEOUT_CYCLES - 32'd1) begin
          err_d   = ERR_TMO;
          state_d = S_DONE;
        end else begin
          tcnt_d = tcnt_q + 32'd1;
        end
      end
      S_READ_CTRL: begin
        if (m.m_arready) begin
          ar_pend_d = 1'b0;
          state_d   = S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        // ap_done is clear-on-read; reading it is the acknowledge, value ignored.
        if (m.m_rvalid) begin
          err_d   = (m.m_rresp != 2'b00) ? ERR_AXI : ERR_OK;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign m.m_awvalid = aw_pend_q;
  assign m.m_awaddr  = wr_addr;
  assign m.m_wvalid  = w_pend_q;
  assign m.m_wdata   = wr_data;
  assign m.m_wstrb   = 4'hF;
  assign m.m_bready  = (state_q == S_WAIT_B);
  assign m.m_arvalid = ar_pend_q;
  assign m.m_araddr  = 6'h00;
  assign m.m_rready  = (state_q == S_WAIT_R);

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign done_valid = (state_q == S_DONE);
  assign done_err   = (state_q == S_DONE) ? err_q : 2'd0;
  assign state_dbg  = state_q;

  assign unused_rdata = ^m.m_rdata;

endmodule

// File: tb/tb_hls_ctrl_sequencer.sv
// Directed bench for hls_ctrl_sequencer: a scripted AXI-Lite slave and
// accelerator model, with a queue scoreboard over writes, reads and completions.
module tb_hls_ctrl_sequencer;
  localparam int W = 44;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_arg0 = '0;
  logic [31:0] cmd_arg1 = '0;
  logic        done_valid;
  logic [1:0]  done_err;
  logic        busy;
  logic        interrupt;
  logic [2:0]  state_dbg;

  hls_ctrl_sequencer_if axi ();

  hls_ctrl_sequencer #(.TIMEOUT_CYCLES(32'd100)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_arg0   (cmd_arg0),
    .cmd_arg1   (cmd_arg1),
    .done_valid (done_valid),
    .done_err   (done_err),
    .busy       (busy),
    .interrupt  (interrupt),
    .m          (axi),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_pass = 0;
  int n_total = 0;
  int exp_lat = -1;
  int ctrl_b_cyc = 0;

  task automatic check_entry(input string name, input logic [W-1:0] act);
    logic [W-1:0] e;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: got %h, expected nothing", name, act);
    end else begin
      e = exp_q.pop_front();
      if (e === act) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, e);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic push_write(input logic [5:0] a, input logic [31:0] d);
    exp_q.push_back({2'd0, a, 4'hF, d});
  endtask
  task automatic push_read(input logic [5:0] a);
    exp_q.push_back({2'd1, a, 4'h0, 32'h0});
  endtask
  task automatic push_done(input logic [1:0] e);
    exp_q.push_back({2'd2, 6'd0, 4'd0, 30'd0, e});
  endtask

  // ---------------- monitor ----------------
  logic [5:0]  cap_addr;
  logic [3:0]  cap_strb;
  logic [31:0] cap_data;
  bit have_a = 0, have_w = 0;
  int mon_b_num = 0;

  initial begin
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        have_a = 0;
        have_w = 0;
      end else begin
        if (cmd_valid && cmd_ready) mon_b_num = 0;
        if (axi.m_awvalid && axi.m_awready) begin
          cap_addr = axi.m_awaddr;
          have_a = 1;
        end
        if (axi.m_wvalid && axi.m_wready) begin
          cap_data = axi.m_wdata;
          cap_strb = axi.m_wstrb;
          have_w = 1;
        end
        if (have_a && have_w) begin
          check_entry("axi_write", {2'd0, cap_addr, cap_strb, cap_data});
          have_a = 0;
          have_w = 0;
        end
        if (axi.m_bvalid && axi.m_bready) begin
          mon_b_num++;
          if (mon_b_num == 5) ctrl_b_cyc = cyc + 1;
        end
        if (axi.m_arvalid && axi.m_arready)
          check_entry("axi_read", {2'd1, axi.m_araddr, 4'h0, 32'h0});
        if (done_valid) begin
          check_entry("done", {2'd2, 6'd0, 4'd0, 30'd0, done_err});
          if (exp_lat >= 0) check_val("done_latency", cyc - ctrl_b_cyc, exp_lat);
        end
      end
    end
  end

  // ---------------- slave / accelerator model ----------------
  int aw_lag = 0, w_lag = 0, b_lag = 0, err_idx = -1, irq_delay = -1;
  int w_cnt, aw_cnt, b_cnt, irq_cnt, wr_num;
  bit got_aw, got_w, b_pend, irq_arm;
  bit aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, aw_v_s, w_v_s, cmd_hs_s;
  logic [5:0] aw_addr_s;

  initial begin
    axi.m_awready = 1'b0; axi.m_wready = 1'b0; axi.m_bvalid = 1'b0; axi.m_bresp = 2'b00;
    axi.m_arready = 1'b0; axi.m_rvalid = 1'b0; axi.m_rdata = '0; axi.m_rresp = 2'b00;
    interrupt = 1'b0;
    forever begin
      @(negedge aclk);
      aw_hs_s  = axi.m_awvalid && axi.m_awready;
      w_hs_s   = axi.m_wvalid && axi.m_wready;
      b_hs_s   = axi.m_bvalid && axi.m_bready;
      ar_hs_s  = axi.m_arvalid && axi.m_arready;
      r_hs_s   = axi.m_rvalid && axi.m_rready;
      aw_v_s   = axi.m_awvalid;
      w_v_s    = axi.m_wvalid;
      aw_addr_s = axi.m_awaddr;
      cmd_hs_s = cmd_valid && cmd_ready;
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        axi.m_awready = 1'b0; axi.m_wready = 1'b0; axi.m_bvalid = 1'b0; axi.m_bresp = 2'b00;
        axi.m_arready = 1'b0; axi.m_rvalid = 1'b0; axi.m_rresp = 2'b00;
        interrupt = 1'b0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; irq_cnt = 0; wr_num = 0;
        got_aw = 0; got_w = 0; b_pend = 0; irq_arm = 0;
      end else begin
        if (cmd_hs_s) wr_num = 0;
        if (irq_arm) begin
          if (irq_cnt == 0) begin interrupt = 1'b1; irq_arm = 0; end
          else irq_cnt--;
        end
        if (aw_hs_s) begin
          got_aw = 1;
          if (aw_addr_s == 6'h0C) interrupt = 1'b0;
        end
        if (aw_lag == 0) axi.m_awready = 1'b1;
        else if (aw_hs_s || !aw_v_s) begin axi.m_awready = 1'b0; aw_cnt = 0; end
        else if (!axi.m_awready) begin aw_cnt++; if (aw_cnt >= aw_lag) axi.m_awready = 1'b1; end
        if (w_hs_s) got_w = 1;
        if (w_lag == 0) axi.m_wready = 1'b1;
        else if (w_hs_s || !w_v_s) begin axi.m_wready = 1'b0; w_cnt = 0; end
        else if (!axi.m_wready) begin w_cnt++; if (w_cnt >= w_lag) axi.m_wready = 1'b1; end
        if (b_hs_s) begin
          axi.m_bvalid = 1'b0;
          wr_num++;
          if (wr_num == 5 && irq_delay > 0) begin irq_arm = 1; irq_cnt = irq_delay - 1; end
        end
        if (got_aw && got_w && !b_pend && !axi.m_bvalid) begin
          b_pend = 1; b_cnt = b_lag; got_aw = 0; got_w = 0;
        end
        if (b_pend) begin
          if (b_cnt == 0) begin
            axi.m_bvalid = 1'b1;
            axi.m_bresp  = (wr_num == err_idx) ? 2'b10 : 2'b00;
            b_pend = 0;
          end else b_cnt--;
        end
        axi.m_arready = 1'b1;
        if (r_hs_s) axi.m_rvalid = 1'b0;
        if (ar_hs_s) begin axi.m_rvalid = 1'b1; axi.m_rdata = 32'h2; axi.m_rresp = 2'b00; end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic configure(input int aw, input int w, input int b, input int e,
                           input int irq, input int lat);
    aw_lag = aw; w_lag = w; b_lag = b; err_idx = e; irq_delay = irq; exp_lat = lat;
  endtask

  task automatic start_cmd(input logic [31:0] a0, input logic [31:0] a1);
    bit ok = 0;
    @(posedge aclk); #1;
    cmd_valid = 1'b1; cmd_arg0 = a0; cmd_arg1 = a1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge aclk);
      if (cmd_ready) ok = 1;
    end
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
    check_val("cmd_accepted", int'(ok), 1);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge aclk);
      if (done_valid) seen = 1;
    end
    check_val("done_seen", int'(seen), 1);
    @(negedge aclk);
    check_val("idle_after_done", int'(cmd_ready && !busy), 1);
    check_val("queue_drained", exp_q.size(), 0);
  endtask

  task automatic push_full_job(input logic [31:0] a0, input logic [31:0] a1);
    push_write(6'h10, a0); push_write(6'h18, a1);
    push_write(6'h04, 32'd1); push_write(6'h08, 32'd1);
    push_write(6'h00, 32'd1); push_write(6'h0C, 32'd1);
    push_read(6'h00);
    push_done(2'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_cmd_ready"}, int'(cmd_ready), 1);
    check_val({tag, "_busy"}, int'(busy), 0);
    check_val({tag, "_valids"},
              int'({axi.m_awvalid, axi.m_wvalid, axi.m_arvalid, axi.m_bready, axi.m_rready}), 0);
    check_val({tag, "_done"}, int'({done_valid, done_err}), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit in_b;
    repeat (4) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    check_idle_outputs("reset");

    // nominal job
    configure(0, 0, 0, -1, 50, -1);
    push_full_job(32'h1000_0000, 32'h2000_0000);
    start_cmd(32'h1000_0000, 32'h2000_0000);
    wait_done();

    // AW accepted 3 cycles ahead of W on every write
    configure(0, 3, 0, -1, 50, -1);
    push_full_job(32'hDEAD_BEEF, 32'h1234_5678);
    start_cmd(32'hDEAD_BEEF, 32'h1234_5678);
    wait_done();

    // SLVERR on the ARG1 write aborts the sequence
    configure(0, 0, 0, 1, 50, -1);
    push_write(6'h10, 32'hA5A5_0001); push_write(6'h18, 32'h5A5A_0002);
    push_done(2'd1);
    start_cmd(32'hA5A5_0001, 32'h5A5A_0002);
    wait_done();
    repeat (20) @(posedge aclk);

    // interrupt never arrives: timeout 100 cycles after WAIT_IRQ entry
    configure(0, 0, 0, -1, -1, 100);
    push_write(6'h10, 32'h0000_0011); push_write(6'h18, 32'h0000_0022);
    push_write(6'h04, 32'd1); push_write(6'h08, 32'd1); push_write(6'h00, 32'd1);
    push_done(2'd2);
    start_cmd(32'h0000_0011, 32'h0000_0022);
    wait_done();
    repeat (20) @(posedge aclk);

    // interrupt rises on the last timeout cycle
    configure(0, 0, 0, -1, 99, -1);
    push_full_job(32'hCAFE_0000, 32'h0000_F00D);
    start_cmd(32'hCAFE_0000, 32'h0000_F00D);
    wait_done();

    // reset pulse while waiting on the first write response
    configure(0, 0, 5, -1, 50, -1);
    push_write(6'h10, 32'h7777_0000);
    start_cmd(32'h7777_0000, 32'h8888_0000);
    in_b = 0;
    for (int i = 0; i < 50 && !in_b; i++) begin
      @(negedge aclk);
      if (axi.m_bready && !axi.m_bvalid) in_b = 1;
    end
    check_val("reached_wait_b", int'(in_b), 1);
    aresetn = 1'b0;
    @(posedge aclk); #2;
    aresetn = 1'b1;
    @(negedge aclk);
    check_idle_outputs("midreset");
    check_val("midreset_queue", exp_q.size(), 0);
    repeat (10) @(posedge aclk);
    configure(0, 0, 0, -1, 50, -1);
    push_full_job(32'h1357_9BDF, 32'h2468_ACE0);
    start_cmd(32'h1357_9BDF, 32'h2468_ACE0);
    wait_done();

    repeat (5) @(posedge aclk);
    check_val("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/hls_ctrl_sequencer.md
HLS_CTRL_SEQUENCER -- requirements
Module: hls_ctrl_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 32'd1_000_000: max cycles from ap_start write to interrupt.
REQ-002 Parameter ARG0_OFFSET, default 6'h10: control-register offset of argument 0.
REQ-003 Parameter ARG1_OFFSET, default 6'h18: control-register offset of argument 1.
REQ-004 aclk  input  1  sole clock; all logic on rising edge.
REQ-005 aresetn  input  1  reset, synchronous, active-low.
REQ-006 cmd_valid / cmd_ready  input/output  1/1  job request handshake.
REQ-007 cmd_arg0, cmd_arg1  input  32 each  argument values, captured on cmd handshake.
REQ-008 done_valid  output  1  one-cycle job-completion pulse.
REQ-009 done_err  output  2  valid with done_valid: 0 ok, 1 AXI-Lite error response, 2 timeout.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 interrupt  input  1  level interrupt from the accelerator.
REQ-012 m_awvalid/m_awready/m_awaddr[5:0], m_wvalid/m_wready/m_wdata[31:0]/m_wstrb[3:0], m_bvalid/m_bready/m_bresp[1:0]: AXI-Lite master write channels.
REQ-013 m_arvalid/m_arready/m_araddr[5:0], m_rvalid/m_rready/m_rdata[31:0]/m_rresp[1:0]: AXI-Lite master read channels.

Function
REQ-014 States: IDLE, WRITE, WAIT_B, WAIT_IRQ, CLR_ISR, READ_CTRL, WAIT_R, DONE.
REQ-015 IDLE: cmd_ready=1; on cmd_valid&cmd_ready, latch args, set write index 0, go WRITE.
REQ-016 Write list, fixed order: idx0 ARG0_OFFSET<=arg0; idx1 ARG1_OFFSET<=arg1; idx2 0x04 (GIE)<=1; idx3 0x08 (IER)<=1; idx4 0x00 (CTRL)<=1 (ap_start).
REQ-017 WRITE: assert m_awvalid and m_wvalid in the same cycle, wstrb=4'hF; each valid drops independently on its own handshake; go WAIT_B once both have handshaken (same or different cycles).
REQ-018 m_awaddr/m_wdata stay stable while the corresponding valid is high.
REQ-019 WAIT_B: m_bready=1; on m_bvalid with bresp!=0, go DONE with err=1; otherwise advance the index, go WRITE, or WAIT_IRQ after idx4.
REQ-020 Timeout counter clears on entry to WAIT_IRQ and increments each WAIT_IRQ cycle; at count==TIMEOUT_CYCLES-1 without interrupt, go DONE with err=2.
REQ-021 WAIT_IRQ: interrupt=1 -> CLR_ISR; interrupt and timeout in the same cycle -> interrupt wins.
REQ-022 CLR_ISR: write 0x0C (ISR)<=1 using the REQ-017/019 handshake rules; error -> DONE err=1; OK -> READ_CTRL.
REQ-023 READ_CTRL: m_araddr=0x00, m_arvalid high until m_arready, then WAIT_R with m_rready=1.
REQ-024 WAIT_R: on m_rvalid, rresp!=0 -> err=1; otherwise err=0 (rdata bit1 ap_done is clear-on-read and is not checked); go DONE.
REQ-025 DONE: done_valid=1 for exactly one cycle, then IDLE; cmd_ready=0 in DONE.
REQ-026 On timeout, no further AXI-Lite transactions are issued; the accelerator is left running.
REQ-027 Only one job outstanding; cmd_ready=0 outside IDLE; no AXI-Lite request is outstanding in IDLE.
REQ-028 Every AXI-Lite valid is held until its handshake completes; no combinational path from any ready to any valid.

Reset
REQ-029 aresetn=0 sampled at an edge -> state IDLE; write index, timeout counter and latched args cleared.
REQ-030 Output reset values: cmd_ready=1 after reset (IDLE); all m_*valid=0; m_bready=0; m_rready=0; done_valid=0; done_err=0; busy=0.
REQ-031 Reset mid-transaction aborts it immediately with no completion pulse; the slave side must also be reset.

Verification
REQ-032 Nominal: arg0=0x1000_0000, arg1=0x2000_0000, ready-always slave, interrupt 50 cycles after the CTRL write -> six writes in order 0x10,0x18,0x04,0x08,0x00,0x0C with data arg0,arg1,1,1,1,1; one read of 0x00; done_valid once with done_err=0.
REQ-033 Skewed handshake: m_awready asserted 3 cycles before m_wready on every write -> each write issued exactly once, same address/data sequence, done_err=0.
REQ-034 Error: bresp=2'b10 on the ARG1 write -> no further writes, done_valid with done_err=1, then IDLE.
REQ-035 Timeout: TIMEOUT_CYCLES=100, interrupt never asserted -> done_valid with err=2 exactly 100 cycles after WAIT_IRQ entry; no ISR write.
REQ-036 Boundary: interrupt rises on the final timeout cycle -> CLR_ISR path taken, done_err=0.
REQ-037 Reset: aresetn=0 for one cycle while in WAIT_B -> next cycle all valids 0, cmd_ready=1, no done_valid; a following job completes normally.
